// File: rtl/imem_pkg.sv
// Shared constants and parameter legality checks for the pipelined instruction memory.
// Also holds the helper used to decide whether a fetch address is misaligned.
package imem_pkg;

    localparam int         NOP_WORD   = 0;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic bit is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

    function automatic bit latency_legal(input int latency);
        return (latency >= 1) && (latency <= 4);
    endfunction

    function automatic bit rsp_depth_legal(input int latency, input int rsp_depth);
        return rsp_depth >= latency + 1;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 4) && (depth <= 4096) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response queue between the read pipeline and the consumer.
// Clear empties it in one edge; push and pop on the same edge leave the count unchanged.
module imem_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) store[wr_ptr] <= push_data;
    end

    assign pop_data = store[rd_ptr];
    assign valid    = (count != '0);

endmodule

// File: rtl/imem_pipelined.sv
// Instruction memory with a fixed-latency read pipeline feeding an in-order response queue.
// Admission is credit based so backpressure never drops or overwrites a response.
module imem_pipelined
    import imem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = LATENCY + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic                     rsp_fault,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int EW = DATA_W + 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);

    if (!latency_legal(LATENCY) || !rsp_depth_legal(LATENCY, RSP_DEPTH) || !depth_legal(DEPTH))
    begin : g_param_err
        $error("imem_pipelined: illegal DEPTH/LATENCY/RSP_DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic              req_fault;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic [EW-1:0]     fifo_out;
    logic [CW-1:0]     fifo_count;
    logic [LATENCY-1:0] st_valid;
    logic [EW-1:0]     st_entry [LATENCY];
    logic [15:0]       occupancy;

    assign word_idx  = req_addr[ADDR_W-1:2];
    assign req_fault = is_misaligned(req_addr[1:0]) || ({1'b0, word_idx} >= (ADDR_W-1)'(DEPTH));

    // A response leaving this cycle frees its slot, which keeps full throughput at RSP_DEPTH = LATENCY+1.
    always_comb begin
        occupancy = 16'(fifo_count) - 16'(pop);
        for (int i = 0; i < LATENCY; i++) begin
            occupancy = occupancy + 16'(st_valid[i]);
        end
    end

    assign pop       = fifo_valid && rsp_ready;
    assign req_ready = rst_n && !flush && (occupancy < 16'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = st_valid[LATENCY-1] && !flush;

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            for (int i = 0; i < LATENCY; i++) st_entry[i] <= '0;
        end else begin
            st_valid[0] <= accept;
            if (accept) st_entry[0] <= req_fault ? {1'b1, NOP} : {1'b0, mem[word_idx[IW-1:0]]};
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1] && !flush;
                st_entry[i] <= st_entry[i-1];
            end
        end
    end

    imem_rsp_fifo #(
        .WIDTH (EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (st_entry[LATENCY-1]),
        .pop       (pop),
        .pop_data  (fifo_out),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign rsp_valid              = fifo_valid;
    assign {rsp_fault, rsp_instr} = fifo_valid ? fifo_out : '0;

endmodule
